instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch stage of the MIPS pipeline: owns the PC, issues single-outstanding requests to instruction memory, and holds the fetched word in an IF/ID register whose opcode field drives the main control decoder. It consumes the resolved branch/jump outcome (Branch, Jump, ALU Zero and targets) from downstream to redirect the PC and squash wrong-path fetches.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- ADDR_W, 32, PC/address width (bits [1:0] always 0)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- imem_req  output  1  fetch request, held until imem_gnt
- imem_addr  output  ADDR_W  word-aligned fetch address, stable while imem_req=1
- imem_gnt  input  1  request accepted this cycle
- imem_rvalid  input  1  read data valid (≥1 cycle after gnt)
- imem_rdata  input  32  instruction word
- id_valid  output  1  IF/ID register holds a valid instruction
- id_ready  input  1  decode consumes IF/ID this cycle when id_valid=1
- id_instr  output  32  fetched instruction
- id_opcode  output  6  id_instr[31:26], to control decoder
- id_pc4  output  ADDR_W  address of id_instr + 4
- br_en  input  1  Branch from decoder, resolved stage
- br_ne  input  1  1 = bne, 0 = beq
- alu_zero  input  1  ALU Zero of rs−rt
- br_target  input  ADDR_W  branch target
- jmp_en  input  1  Jump (j/jal)
- jmp_target  input  ADDR_W  jump target
- perf_fetch_cnt  output  32  delivered instructions (see Configuration)
- perf_flush_cnt  output  32  redirects taken (see Configuration)

## Operation
- taken = jmp_en | (br_en & (alu_zero ^ br_ne)); next PC on redirect = jmp_en ? jmp_target : br_target (jump wins if both).
- States: IDLE, REQ, WAIT.
  - IDLE: entered on reset; next cycle → REQ.
  - REQ: imem_req=1, imem_addr=pc. Issue only if IF/ID empty or being drained (id_valid&id_ready); otherwise imem_req=0 and remain. On imem_gnt → WAIT, pc ← pc+4.
  - WAIT: on imem_rvalid load IF/ID (id_valid=1, id_instr=rdata, id_pc4=req address+4) → REQ.
- Single outstanding request; max throughput one instruction per 2 cycles.
- Redirect (taken=1), any state, registered:
  - pc ← target; IF/ID cleared (id_valid=0) next cycle, overriding id_ready.
  - In REQ without gnt: request withdrawn, re-issued next cycle with target.
  - In REQ with simultaneous gnt, or in WAIT: set discard flag; matching rvalid data dropped (IF/ID not loaded), then → REQ with target. rvalid in same cycle as redirect is also dropped.
- IF/ID load and drain in same cycle: new word replaces old, id_valid stays 1.
- id_opcode is purely combinational from id_instr.

## Timing
- Reset (async assert, sync release): pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=RESET_PC, id_valid=0, id_instr=0, id_pc4=0, discard=0, counters=0.
- First imem_req=1 on 2nd rising edge after rst_n deasserts.
- imem_rvalid → id_valid: 1 cycle (registered).
- Redirect seen at edge N → imem_addr=target and id_valid=0 after edge N.
- PC wraps modulo 2^ADDR_W; bits [1:0] forced 0.
- Reset mid-request: all state cleared; any later rvalid ignored while state≠WAIT.

## Configuration
- IFU_PERF_CNT_EN defined: perf_fetch_cnt increments on each IF/ID load; perf_flush_cnt increments on each redirect; both wrap at 2^32, reset to 0.
- Undefined: counters not built; both ports tied to 0.

## Test plan
- Reset release, imem gnt same cycle, rvalid 1 cycle later, rdata=32'h8C08_0004 -> imem_addr 0,4,8…; id_opcode=6'd35, id_pc4=4.
- id_ready=0 for 5 cycles with id_valid=1 -> imem_req=0, id_instr unchanged; resume after id_ready=1.
- br_en=1, br_ne=0, alu_zero=1, br_target=32'h40 while in WAIT -> returned word dropped, id_valid=0, next imem_addr=32'h40.
- br_en=1, br_ne=1, alu_zero=1 -> no redirect, sequential fetch continues.
- jmp_en=1 and br_en taken same cycle, jmp_target=32'h100, br_target=32'h80 -> next imem_addr=32'h100.
- With IFU_PERF_CNT_EN: 10 deliveries + 2 redirects -> perf_fetch_cnt=10, perf_flush_cnt=2; without macro both read 0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: MIPS IF stage. Owns the PC, keeps at most one instruction
// memory request in flight, holds the fetched word in the IF/ID register and
// redirects on a resolved branch or jump.
// Optional build macro: IFU_PERF_CNT_EN enables the fetch/flush counters.
// When it is not defined, perf_fetch_cnt and perf_flush_cnt read 0.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [31:0]       id_instr,
    output logic [5:0]        id_opcode,
    output logic [ADDR_W-1:0] id_pc4,
    input  logic              br_en,
    input  logic              br_ne,
    input  logic              alu_zero,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              jmp_en,
    input  logic [ADDR_W-1:0] jmp_target,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_flush_cnt
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(3));

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic              discard, discard_nxt;
    logic              taken;
    logic [ADDR_W-1:0] redir_pc;
    logic              load;

    // Redirect decode: jump has priority over a taken branch
    always_comb begin
        taken    = jmp_en | (br_en & (alu_zero ^ br_ne));
        redir_pc = (jmp_en ? jmp_target : br_target) & ALIGN_MASK;
    end

    // Request only while IF/ID has room (empty or draining this cycle)
    assign imem_req  = (state == REQ) && (!id_valid || id_ready);
    assign imem_addr = pc;
    assign id_opcode = id_instr[31:26];

    // Next-state, PC and discard-flag logic
    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        discard_nxt = discard;
        load        = 1'b0;
        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                if (imem_req && imem_gnt) begin
                    state_nxt = WAIT;
                    pc_nxt    = pc + PC_STEP;
                    // Accepted request is on the wrong path if we redirect now
                    if (taken) discard_nxt = 1'b1;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_nxt   = REQ;
                    discard_nxt = 1'b0;
                    load        = !discard && !taken;
                end else if (taken) begin
                    discard_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (taken) pc_nxt = redir_pc;
    end

    // FSM, PC and discard registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pc      <= RESET_PC & ALIGN_MASK;
            discard <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            discard <= discard_nxt;
        end
    end

    // IF/ID register. A load only happens with no redirect since the grant,
    // so pc already equals request address + 4 at that point.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid <= 1'b0;
            id_instr <= '0;
            id_pc4   <= '0;
        end else if (taken) begin
            id_valid <= 1'b0;
        end else if (load) begin
            id_valid <= 1'b1;
            id_instr <= imem_rdata;
            id_pc4   <= pc;
        end else if (id_ready) begin
            id_valid <= 1'b0;
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_cnt, flush_cnt;

    // Delivered-instruction and redirect counters, free-running with wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (load)  fetch_cnt <= fetch_cnt + 32'd1;
            if (taken) flush_cnt <= flush_cnt + 32'd1;
        end
    end

    assign perf_fetch_cnt = fetch_cnt;
    assign perf_flush_cnt = flush_cnt;
`else
    assign perf_fetch_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: stimulus pushes expected fetch
// addresses, a memory model answers requests, a monitor checks deliveries.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        id_valid;
    logic        id_ready = 1'b1;
    logic [31:0] id_instr;
    logic [5:0]  id_opcode;
    logic [31:0] id_pc4;
    logic        br_en = 1'b0;
    logic        br_ne = 1'b0;
    logic        alu_zero = 1'b0;
    logic [31:0] br_target = '0;
    logic        jmp_en = 1'b0;
    logic [31:0] jmp_target = '0;
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_flush_cnt;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    int          grants_total = 0;
    int          rv_lat = 1;

    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
        .id_opcode(id_opcode), .id_pc4(id_pc4),
        .br_en(br_en), .br_ne(br_ne), .alu_zero(alu_zero), .br_target(br_target),
        .jmp_en(jmp_en), .jmp_target(jmp_target),
        .perf_fetch_cnt(perf_fetch_cnt), .perf_flush_cnt(perf_flush_cnt)
    );

    always #5 clk = ~clk;

    // Memory contents: lw-style word (opcode 35), low half = address + 4
    function automatic logic [31:0] memword(input logic [31:0] a);
        return {16'h8C08, a[15:0] + 16'd4};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Memory model: grants up to grants_total requests, data rv_lat cycles later
    int          grants_done = 0;
    logic        pending = 1'b0;
    logic [31:0] pend_addr = '0;
    logic [31:0] gaddr = '0;
    int          rv_wait = 0;
    always begin
        @(negedge clk); #2;
        if (imem_gnt) begin
            pending   = 1'b1;
            pend_addr = gaddr;
            rv_wait   = rv_lat - 1;
        end
        imem_rvalid = 1'b0;
        if (pending) begin
            if (rv_wait == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = memword(pend_addr);
                pending     = 1'b0;
            end else begin
                rv_wait--;
            end
        end
        imem_gnt = 1'b0;
        if (imem_req && grants_done < grants_total) begin
            imem_gnt = 1'b1;
            gaddr    = imem_addr;
            grants_done++;
        end
    end

    // Monitor: every consumed IF/ID word must match the head of the scoreboard
    always begin
        @(negedge clk); #4;
        if (rst_n && id_valid && id_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_delivery", id_pc4, 32'hFFFF_FFFF);
            end else begin
                logic [31:0] a;
                a = exp_q.pop_front();
                chk("id_instr", id_instr, memword(a));
                chk("id_pc4", id_pc4, a + 32'd4);
                chk("id_opcode", {26'd0, id_opcode}, 32'd35);
            end
        end
    end

    task automatic wait_empty(input string nm);
        for (int i = 0; i < 80 && exp_q.size() != 0; i++) @(negedge clk);
        chk(nm, exp_q.size(), 0);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_req", {31'd0, imem_req}, 0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'd0, id_valid}, 0);
        chk("rst_instr", id_instr, 32'h0);
        chk("rst_pc4", id_pc4, 32'h0);
        chk("rst_perf_fetch", perf_fetch_cnt, 0);
        chk("rst_perf_flush", perf_flush_cnt, 0);

        // Sequential fetch from reset
        grants_total += 4;
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        exp_q.push_back(32'h8); exp_q.push_back(32'hC);
        @(negedge clk);
        rst_n = 1'b1;
        chk("idle_req", {31'd0, imem_req}, 0);
        @(negedge clk);
        chk("first_req", {31'd0, imem_req}, 1);
        chk("first_addr", imem_addr, 32'h0);
        wait_empty("seq_drain");

        // Decode stall holds IF/ID and blocks new requests
        id_ready = 1'b0;
        grants_total += 2;
        exp_q.push_back(32'h10); exp_q.push_back(32'h14);
        for (int i = 0; i < 20 && !id_valid; i++) @(negedge clk);
        chk("stall_loaded", {31'd0, id_valid}, 1);
        for (int i = 0; i < 5; i++) begin
            chk("stall_req", {31'd0, imem_req}, 0);
            chk("stall_instr", id_instr, memword(32'h10));
            @(negedge clk);
        end
        id_ready = 1'b1;
        wait_empty("stall_drain");

        // beq taken while waiting for data: word dropped, refetch at 0x40
        rv_lat = 3;
        grants_total += 1;
        @(negedge clk);
        br_en = 1'b1; br_ne = 1'b0; alu_zero = 1'b1; br_target = 32'h40;
        @(negedge clk);
        br_en = 1'b0;
        chk("beq_addr", imem_addr, 32'h40);
        chk("beq_valid", {31'd0, id_valid}, 0);
        chk("beq_req_wait", {31'd0, imem_req}, 0);
        rv_lat = 1;
        grants_total += 2;
        exp_q.push_back(32'h40); exp_q.push_back(32'h44);
        wait_empty("beq_drain");

        // bne with zero=1 is not taken: sequential fetch continues
        grants_total += 2;
        exp_q.push_back(32'h48); exp_q.push_back(32'h4C);
        br_en = 1'b1; br_ne = 1'b1; alu_zero = 1'b1; br_target = 32'h200;
        @(negedge clk);
        br_en = 1'b0; br_ne = 1'b0;
        wait_empty("bne_drain");
        chk("bne_addr", imem_addr, 32'h50);

        // Jump and taken branch together: jump wins, request re-issued
        jmp_en = 1'b1; jmp_target = 32'h100;
        br_en = 1'b1; alu_zero = 1'b1; br_target = 32'h80;
        @(negedge clk);
        jmp_en = 1'b0; br_en = 1'b0;
        chk("jmp_addr", imem_addr, 32'h100);
        chk("jmp_reissue", {31'd0, imem_req}, 1);
        grants_total += 1;
        exp_q.push_back(32'h100);
        wait_empty("jmp_drain");

        // Redirect in the same cycle as a grant: granted word discarded
        grants_total += 1;
        br_en = 1'b1; alu_zero = 1'b1; br_target = 32'h20;
        @(negedge clk);
        br_en = 1'b0;
        chk("gnt_redir_addr", imem_addr, 32'h20);
        chk("gnt_redir_req", {31'd0, imem_req}, 0);
        grants_total += 1;
        exp_q.push_back(32'h20);
        wait_empty("gnt_redir_drain");

        // Performance counters: 12 deliveries, 3 redirects
        @(negedge clk);
`ifdef IFU_PERF_CNT_EN
        chk("perf_fetch", perf_fetch_cnt, 12);
        chk("perf_flush", perf_flush_cnt, 3);
`else
        chk("perf_fetch", perf_fetch_cnt, 0);
        chk("perf_flush", perf_flush_cnt, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule
